// File: rtl/mp_regfile_sb_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
// Used by the register file, the issue stage and the writeback stage.
package mp_regfile_sb_pkg;

  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_NUM_RD    = 4;
  localparam int RF_NUM_WR    = 2;
  localparam int RF_NUM_ALLOC = 2;

  // Architectural zero register: reads as 0, never busy, ignores writes/allocs.
  localparam int RF_ZERO_REG  = 0;

endpackage

// File: rtl/mp_regfile_sb_scoreboard.sv
// Busy scoreboard for mp_regfile_sb: one busy bit per register.
// Priority at each edge: flush clears all, else alloc sets, else writeback clears.
module mp_regfile_sb_scoreboard
  import mp_regfile_sb_pkg::*;
#(
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter int NUM_WR    = RF_NUM_WR,
  parameter int NUM_ALLOC = RF_NUM_ALLOC
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr_i,
  input  logic [NUM_WR-1:0]           wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]    wr_addr_i,
  input  logic [NUM_ALLOC-1:0]        alloc_en_i,
  input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr_i,
  input  logic                        flush_i,
  output logic [(1<<ADDR_W)-1:0]      busy_vec_o,
  output logic [NUM_RD-1:0]           rd_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy state: clears first, then sets, so an alloc beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) busy_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (alloc_en_i[a]) busy_d[alloc_addr_i[a*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (flush_i) busy_d = '0;
    busy_d[ZERO_ADDR] = 1'b0;
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Per-read-port lookup of stored busy state.
  always_comb begin
    rd_busy_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_addr_i[r*ADDR_W +: ADDR_W] != ZERO_ADDR)
        rd_busy_o[r] = busy_q[rd_addr_i[r*ADDR_W +: ADDR_W]];
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/mp_regfile_sb.sv
// Parametrised multi-port register file with busy scoreboard.
// Holds the data array, write-priority merge, write-collision detect and
// the optional same-cycle write->read bypass (enabled by defining RF_BYPASS_EN).
module mp_regfile_sb
  import mp_regfile_sb_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter int NUM_WR    = RF_NUM_WR,
  parameter int NUM_ALLOC = RF_NUM_ALLOC
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]    rd_data_o,
  output logic [NUM_RD-1:0]           rd_busy_o,
  input  logic [NUM_WR-1:0]           wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]    wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]    wr_data_i,
  input  logic [NUM_ALLOC-1:0]        alloc_en_i,
  input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr_i,
  input  logic                        flush_i,
  output logic [(1<<ADDR_W)-1:0]      busy_vec_o,
  output logic                        wr_conflict_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              conflict_d;
  logic              wr_conflict_q;
  logic [NUM_RD-1:0] sb_rd_busy;

  mp_regfile_sb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .NUM_ALLOC(NUM_ALLOC)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_addr_i   (rd_addr_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .alloc_en_i  (alloc_en_i),
    .alloc_addr_i(alloc_addr_i),
    .flush_i     (flush_i),
    .busy_vec_o  (busy_vec_o),
    .rd_busy_o   (sb_rd_busy)
  );

  // Write merge: ports applied in ascending order so the highest index wins.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) mem_d[e] = mem_q[e];
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] != ZERO_ADDR))
        mem_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = wr_data_i[w*DATA_W +: DATA_W];
    end
  end

  // Collision: any pair of enabled ports hitting the same nonzero register.
  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            (wr_addr_i[i*ADDR_W +: ADDR_W] == wr_addr_i[j*ADDR_W +: ADDR_W]) &&
            (wr_addr_i[i*ADDR_W +: ADDR_W] != ZERO_ADDR))
          conflict_d = 1'b1;
      end
    end
  end

  // Data array and collision flag, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= mem_d[e];
      wr_conflict_q <= conflict_d;
    end
  end

`ifdef RF_BYPASS_EN
  logic [NUM_RD-1:0] byp_hit;
  logic [NUM_RD-1:0] byp_alloc;

  // Read path with forwarding: a matching in-flight write supplies the data and
  // the register reads as free unless it is being re-allocated this cycle.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    byp_hit   = '0;
    byp_alloc = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_addr_i[r*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
        rd_data_o[r*DATA_W +: DATA_W] = mem_q[rd_addr_i[r*ADDR_W +: ADDR_W]];
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr_i[r*ADDR_W +: ADDR_W])) begin
            rd_data_o[r*DATA_W +: DATA_W] = wr_data_i[w*DATA_W +: DATA_W];
            byp_hit[r] = 1'b1;
          end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
          if (alloc_en_i[a] && !flush_i &&
              (alloc_addr_i[a*ADDR_W +: ADDR_W] == rd_addr_i[r*ADDR_W +: ADDR_W]))
            byp_alloc[r] = 1'b1;
        end
        rd_busy_o[r] = byp_hit[r] ? byp_alloc[r] : sb_rd_busy[r];
      end
    end
  end
`else
  // Read path without forwarding: stored state only.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = sb_rd_busy;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_addr_i[r*ADDR_W +: ADDR_W] != ZERO_ADDR)
        rd_data_o[r*DATA_W +: DATA_W] = mem_q[rd_addr_i[r*ADDR_W +: ADDR_W]];
    end
  end
`endif

  assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Directed bench for mp_regfile_sb with default parameters.
module tb_mp_regfile_sb;

  logic         clk_i;
  logic         rst_i;
  logic [19:0]  rd_addr_i;
  logic [127:0] rd_data_o;
  logic [3:0]   rd_busy_o;
  logic [1:0]   wr_en_i;
  logic [9:0]   wr_addr_i;
  logic [63:0]  wr_data_i;
  logic [1:0]   alloc_en_i;
  logic [9:0]   alloc_addr_i;
  logic         flush_i;
  logic [31:0]  busy_vec_o;
  logic         wr_conflict_o;

  int n_chk;
  int n_fail;

  mp_regfile_sb dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_busy_o    (rd_busy_o),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .alloc_en_i   (alloc_en_i),
    .alloc_addr_i (alloc_addr_i),
    .flush_i      (flush_i),
    .busy_vec_o   (busy_vec_o),
    .wr_conflict_o(wr_conflict_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rd_addr_i    = '0;
    wr_en_i      = '0;
    wr_addr_i    = '0;
    wr_data_i    = '0;
    alloc_en_i   = '0;
    alloc_addr_i = '0;
    flush_i      = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en_i[p]          = 1'b1;
    wr_addr_i[p*5 +: 5] = a;
    wr_data_i[p*32 +: 32] = d;
  endtask

  task automatic set_alloc(input int p, input logic [4:0] a);
    alloc_en_i[p]          = 1'b1;
    alloc_addr_i[p*5 +: 5] = a;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr_i[p*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rdd(input int p);
    return rd_data_o[p*32 +: 32];
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_i  = 1'b1;
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    set_rd(0, 5'd1);
    #1;
    check("rst_busy_vec", busy_vec_o, 32'h0);
    check("rst_conflict", wr_conflict_o, 1'b0);
    check("rst_rd_r1", rdd(0), 32'h0);
    #1;

    // Dual write
    idle();
    set_wr(0, 5'd5, 32'hAAAA_AAAA);
    set_wr(1, 5'd10, 32'h5555_5555);
    tick();
    idle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd10);
    #1;
    check("dual_rd_r5", rdd(0), 32'hAAAA_AAAA);
    check("dual_rd_r10", rdd(1), 32'h5555_5555);
    check("dual_no_conflict", wr_conflict_o, 1'b0);

    // Collision: higher-index port wins, one-cycle pulse
    set_wr(0, 5'd7, 32'h1111_1111);
    set_wr(1, 5'd7, 32'h2222_2222);
    tick();
    idle();
    set_rd(2, 5'd7);
    #1;
    check("coll_pulse", wr_conflict_o, 1'b1);
    check("coll_r7", rdd(2), 32'h2222_2222);
    tick();
    check("coll_pulse_end", wr_conflict_o, 1'b0);

    // Zero register
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    set_alloc(0, 5'd0);
    set_rd(3, 5'd0);
    #1;
    check("zero_rd_same", rdd(3), 32'h0);
    tick();
    idle();
    set_rd(3, 5'd0);
    #1;
    check("zero_rd", rdd(3), 32'h0);
    check("zero_busy", rd_busy_o[3], 1'b0);
    check("zero_busy_vec", busy_vec_o, 32'h0);
    check("zero_no_conflict", wr_conflict_o, 1'b0);

    // Scoreboard
    set_alloc(0, 5'd3);
    tick();
    idle();
    set_rd(0, 5'd3);
    #1;
    check("sb_alloc_vec", busy_vec_o, 32'h0000_0008);
    check("sb_alloc_rdbusy", rd_busy_o[0], 1'b1);
    set_wr(0, 5'd3, 32'h0000_0033);
    set_alloc(1, 5'd3);
    tick();
    idle();
    check("sb_alloc_wb_same", busy_vec_o, 32'h0000_0008);
    set_wr(0, 5'd3, 32'h0000_0034);
    tick();
    idle();
    set_rd(1, 5'd3);
    #1;
    check("sb_wb_clear", busy_vec_o, 32'h0);
    check("sb_wb_data", rdd(1), 32'h0000_0034);
    set_alloc(0, 5'd8);
    set_alloc(1, 5'd8);
    tick();
    idle();
    check("sb_dup_alloc", busy_vec_o, 32'h0000_0100);
    flush_i = 1'b1;
    set_alloc(0, 5'd4);
    set_wr(1, 5'd12, 32'h0000_C0C0);
    tick();
    idle();
    set_rd(2, 5'd12);
    #1;
    check("sb_flush_vec", busy_vec_o, 32'h0);
    check("sb_flush_wr_data", rdd(2), 32'h0000_C0C0);

    // Bypass vs stored read
    set_wr(0, 5'd9, 32'h1234_5678);
    tick();
    idle();
    set_alloc(0, 5'd9);
    tick();
    idle();
    check("byp_pre_busy", busy_vec_o, 32'h0000_0200);
    set_wr(1, 5'd9, 32'hDEAD_BEEF);
    set_rd(0, 5'd9);
    #1;
`ifdef RF_BYPASS_EN
    check("byp_same_data", rdd(0), 32'hDEAD_BEEF);
    check("byp_same_busy", rd_busy_o[0], 1'b0);
`else
    check("nobyp_same_data", rdd(0), 32'h1234_5678);
    check("nobyp_same_busy", rd_busy_o[0], 1'b1);
`endif
    tick();
    idle();
    set_rd(0, 5'd9);
    #1;
    check("byp_next_data", rdd(0), 32'hDEAD_BEEF);
    check("byp_next_busy", rd_busy_o[0], 1'b0);

    // Asynchronous reset mid-run
    set_wr(0, 5'd20, 32'h0000_0001);
    set_wr(1, 5'd20, 32'h0000_0002);
    set_alloc(0, 5'd21);
    tick();
    idle();
    set_rd(0, 5'd20);
    set_rd(1, 5'd5);
    #1;
    check("pre_rst_conflict", wr_conflict_o, 1'b1);
    check("pre_rst_busy_vec", busy_vec_o, 32'h0020_0000);
    check("pre_rst_r20", rdd(0), 32'h0000_0002);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst_r20", rdd(0), 32'h0);
    check("arst_r5", rdd(1), 32'h0);
    check("arst_busy_vec", busy_vec_o, 32'h0);
    check("arst_conflict", wr_conflict_o, 1'b0);
    set_wr(0, 5'd5, 32'hFFFF_0000);
    tick();
    check("arst_hold_r5", rdd(1), 32'h0);
    rst_i = 1'b0;
    idle();
    set_rd(1, 5'd5);
    #1;
    check("post_rst_r5", rdd(1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
